// File: rtl/eth_echo_engine.sv
// eth_echo_engine: copies each received packet into the transmit buffer.
// Define ECHO_MAC_SWAP_EN to swap destination and source MAC addresses.
module eth_echo_engine #(
  parameter int eth_mtu_p = 2048,
  parameter int data_width_p = 32,
  localparam int bytes_lp = data_width_p / 8,
  localparam int lg_lp = $clog2(bytes_lp),
  localparam int safe_lg_lp = (bytes_lp > 1) ? lg_lp : 1,
  localparam int size_width_lp = $clog2(safe_lg_lp + 1),
  localparam int addr_width_lp = $clog2(eth_mtu_p),
  localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            enable_i,
  input  logic                            packet_avail_i,
  input  logic [packet_size_width_lp-1:0] packet_rsize_i,
  output logic                            packet_rvalid_o,
  output logic [addr_width_lp-1:0]        packet_raddr_o,
  output logic [size_width_lp-1:0]        packet_rdata_size_o,
  input  logic [data_width_p-1:0]         packet_rdata_i,
  output logic                            packet_ack_o,
  input  logic                            packet_req_i,
  output logic                            packet_wvalid_o,
  output logic [addr_width_lp-1:0]        packet_waddr_o,
  output logic [data_width_p-1:0]         packet_wdata_o,
  output logic [size_width_lp-1:0]        packet_wdata_size_o,
  output logic                            packet_wsize_valid_o,
  output logic [packet_size_width_lp-1:0] packet_wsize_o,
  output logic                            packet_send_o,
  output logic [15:0]                     echo_count_o,
  output logic [15:0]                     drop_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DROP, S_WAIT, S_COPY, S_DRAIN, S_COMMIT, S_GAP
  } state_e;

  localparam int iw_lp = addr_width_lp + 1;
  localparam int rw_lp = packet_size_width_lp + 1;
  localparam logic [size_width_lp-1:0] full_sz_lp = size_width_lp'(lg_lp);
  localparam logic [rw_lp-1:0] pad_lp = rw_lp'(bytes_lp - 1);

  state_e r_state, w_state_n;
  logic [packet_size_width_lp-1:0] r_size;
  logic [iw_lp-1:0] r_idx, w_idx_n, w_nrd;
  logic [rw_lp-1:0] w_round;
  logic [addr_width_lp-1:0] r_raddr, r_dst, r_waddr;
  logic [addr_width_lp-1:0] w_raddr_n, w_dst_n;
  logic [size_width_lp-1:0] r_rsz, r_wsz, w_rsz_n;
  logic r_rvalid, r_wvalid, r_ack, r_send, r_wsv;
  logic [15:0] r_echo, r_drop;
  logic w_start, w_last;

`ifdef ECHO_MAC_SWAP_EN
  localparam logic [rw_lp-1:0] hdr_lp = rw_lp'(12);
  // 12 bytewise header reads, then full words from byte 12
  assign w_round = {1'b0, r_size} - hdr_lp + pad_lp;
  assign w_nrd = iw_lp'(w_round >> lg_lp) + iw_lp'(12);
`else
  assign w_round = {1'b0, r_size} + pad_lp;
  assign w_nrd = iw_lp'(w_round >> lg_lp);
`endif

  assign w_start = enable_i & packet_avail_i;
  assign w_last = (r_idx == w_nrd - 1'b1);

  always_comb begin
    w_idx_n = '0;
    if (r_state == S_COPY) w_idx_n = r_idx + 1'b1;
    w_raddr_n = addr_width_lp'(w_idx_n << lg_lp);
    w_dst_n = w_raddr_n;
    w_rsz_n = full_sz_lp;
`ifdef ECHO_MAC_SWAP_EN
    if (w_idx_n < iw_lp'(12)) begin
      w_dst_n = addr_width_lp'(w_idx_n);
      w_raddr_n = (w_idx_n < iw_lp'(6))
        ? addr_width_lp'(w_idx_n + iw_lp'(6))
        : addr_width_lp'(w_idx_n - iw_lp'(6));
      w_rsz_n = '0;
    end else begin
      w_raddr_n = addr_width_lp'(
        ((w_idx_n - iw_lp'(12)) << lg_lp) + iw_lp'(12));
      w_dst_n = w_raddr_n;
    end
`endif
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start)
          w_state_n = (packet_rsize_i < packet_size_width_lp'(14))
            ? S_DROP : S_WAIT;
      end
      S_DROP:   w_state_n = S_GAP;
      S_WAIT:   if (packet_req_i) w_state_n = S_COPY;
      S_COPY:   if (w_last) w_state_n = S_DRAIN;
      S_DRAIN:  w_state_n = S_COMMIT;
      S_COMMIT: w_state_n = S_GAP;
      S_GAP:    w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_size   <= '0;
      r_idx    <= '0;
      r_raddr  <= '0;
      r_dst    <= '0;
      r_rsz    <= '0;
      r_rvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_waddr  <= '0;
      r_wsz    <= '0;
      r_ack    <= 1'b0;
      r_send   <= 1'b0;
      r_wsv    <= 1'b0;
      r_echo   <= '0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_IDLE && w_start) r_size <= packet_rsize_i;
      r_rvalid <= (w_state_n == S_COPY);
      if (w_state_n == S_COPY) begin
        r_idx   <= w_idx_n;
        r_raddr <= w_raddr_n;
        r_dst   <= w_dst_n;
        r_rsz   <= w_rsz_n;
      end
      // write trails its read by one cycle, when read data returns
      r_wvalid <= r_rvalid;
      r_waddr  <= r_dst;
      r_wsz    <= r_rsz;
      r_ack  <= (w_state_n == S_DROP) || (w_state_n == S_COMMIT);
      r_send <= (w_state_n == S_COMMIT);
      r_wsv  <= (w_state_n == S_COMMIT);
      if (r_state == S_DROP) r_drop <= r_drop + 1'b1;
      if (r_state == S_COMMIT) r_echo <= r_echo + 1'b1;
    end
  end

  assign packet_rvalid_o = r_rvalid;
  assign packet_raddr_o = r_raddr;
  assign packet_rdata_size_o = r_rsz;
  assign packet_ack_o = r_ack;
  assign packet_wvalid_o = r_wvalid;
  assign packet_waddr_o = r_waddr;
  assign packet_wdata_o = packet_rdata_i;
  assign packet_wdata_size_o = r_wsz;
  assign packet_wsize_valid_o = r_wsv;
  assign packet_wsize_o = r_size;
  assign packet_send_o = r_send;
  assign echo_count_o = r_echo;
  assign drop_count_o = r_drop;

endmodule

// File: tb/tb_eth_echo_engine.sv
// tb_eth_echo_engine: scoreboard bench with rx/tx buffer models.
// Build with ECHO_MAC_SWAP_EN defined to exercise the MAC swap copy.
module tb_eth_echo_engine;
  localparam int MTU = 2048;

  logic clk = 1'b0;
  logic reset_i, enable_i, packet_avail_i, packet_req_i;
  logic [11:0] packet_rsize_i;
  logic packet_rvalid_o, packet_ack_o, packet_wvalid_o;
  logic [10:0] packet_raddr_o, packet_waddr_o;
  logic [1:0] packet_rdata_size_o, packet_wdata_size_o;
  logic [31:0] packet_rdata_i, packet_wdata_o;
  logic packet_wsize_valid_o, packet_send_o;
  logic [11:0] packet_wsize_o;
  logic [15:0] echo_count_o, drop_count_o;

  eth_echo_engine dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .packet_avail_i(packet_avail_i), .packet_rsize_i(packet_rsize_i),
    .packet_rvalid_o(packet_rvalid_o), .packet_raddr_o(packet_raddr_o),
    .packet_rdata_size_o(packet_rdata_size_o),
    .packet_rdata_i(packet_rdata_i), .packet_ack_o(packet_ack_o),
    .packet_req_i(packet_req_i), .packet_wvalid_o(packet_wvalid_o),
    .packet_waddr_o(packet_waddr_o), .packet_wdata_o(packet_wdata_o),
    .packet_wdata_size_o(packet_wdata_size_o),
    .packet_wsize_valid_o(packet_wsize_valid_o),
    .packet_wsize_o(packet_wsize_o), .packet_send_o(packet_send_o),
    .echo_count_o(echo_count_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int sz;
    logic [31:0] data;
  } wr_t;

  byte unsigned rxm [MTU];
  byte unsigned txm [MTU];
  wr_t exp_q [$];
  int n_pass = 0, n_fail = 0, n_tot = 0;
  int n_rv = 0, n_wv = 0, n_ack = 0, n_send = 0;
  int last_wsize = 0, ack_cyc = 0, cyc = 0;
  logic [31:0] rd_w;

  task automatic chk(string tag, longint obs, longint exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int nreads(int size);
`ifdef ECHO_MAC_SWAP_EN
    return 12 + (size - 12 + 3) / 4;
`else
    return (size + 3) / 4;
`endif
  endfunction

  function automatic int src_of(int i);
`ifdef ECHO_MAC_SWAP_EN
    if (i < 12) return (i + 6) % 12;
`endif
    return i;
  endfunction

  // receive buffer: data one cycle after the read strobe
  always @(posedge clk) begin
    cyc++;
    rd_w = '0;
    if (packet_rvalid_o)
      for (int j = 0; j < (1 << packet_rdata_size_o); j++)
        rd_w[8*j +: 8] = rxm[int'(packet_raddr_o) + j];
    packet_rdata_i <= rd_w;
  end

  // transmit buffer and scoreboard
  always @(negedge clk) begin
    wr_t e;
    logic [31:0] m;
    if (packet_rvalid_o) n_rv++;
    if (packet_ack_o) begin
      n_ack++;
      ack_cyc = cyc;
    end
    if (packet_send_o) begin
      n_send++;
      chk("send_with_ack", longint'(packet_ack_o), 1);
    end
    if (packet_wsize_valid_o) last_wsize = int'(packet_wsize_o);
    if (packet_wvalid_o) begin
      n_wv++;
      for (int j = 0; j < (1 << packet_wdata_size_o); j++)
        txm[int'(packet_waddr_o) + j] = packet_wdata_o[8*j +: 8];
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        m = (e.sz == 0) ? 32'h0000_00ff : 32'hffff_ffff;
        chk("wr_addr", longint'(packet_waddr_o), e.addr);
        chk("wr_size", longint'(packet_wdata_size_o), e.sz);
        chk("wr_data", longint'(packet_wdata_o & m),
            longint'(e.data & m));
      end
    end
  end

  task automatic load(int size, int seed, bit mac);
    wr_t e;
    int a;
    for (int i = 0; i < MTU; i++) begin
      rxm[i] = 8'(seed * 31 + i * 7 + 3);
      txm[i] = 8'h00;
    end
    if (mac)
      for (int i = 0; i < 6; i++) begin
        rxm[i] = 8'(11 + i);
        rxm[i + 6] = 8'(21 + i);
      end
    exp_q.delete();
    for (int k = 0; k < nreads(size); k++) begin
`ifdef ECHO_MAC_SWAP_EN
      if (k < 12) begin
        e.addr = k;
        e.sz = 0;
        e.data = {24'h0, rxm[src_of(k)]};
        exp_q.push_back(e);
        continue;
      end
      a = 12 + 4 * (k - 12);
`else
      a = 4 * k;
`endif
      e.addr = a;
      e.sz = 2;
      e.data = {rxm[a+3], rxm[a+2], rxm[a+1], rxm[a]};
      exp_q.push_back(e);
    end
  endtask

  task automatic echo(int size, int seed, int req_dly, bit mac,
                      string tag);
    int rv0, wv0, s0, a0, st, t, bad;
    load(size, seed, mac);
    rv0 = n_rv; wv0 = n_wv; s0 = n_send; a0 = n_ack;
    if (req_dly > 0) packet_req_i = 1'b0;
    packet_rsize_i = 12'(size);
    packet_avail_i = 1'b1;
    st = cyc;
    if (req_dly > 0) begin
      repeat (req_dly) tick();
      chk({tag, "_no_read_before_req"}, n_rv - rv0, 0);
      packet_req_i = 1'b1;
    end
    for (t = 0; t < 300 && n_ack == a0; t++) tick();
    chk({tag, "_ack_timeout"}, longint'(n_ack != a0), 1);
    packet_avail_i = 1'b0;
    tick();
    tick();
    if (req_dly == 0)
      chk({tag, "_cycles"}, ack_cyc - st + 2, nreads(size) + 5);
    chk({tag, "_reads"}, n_rv - rv0, nreads(size));
    chk({tag, "_writes"}, n_wv - wv0, nreads(size));
    chk({tag, "_wsize"}, last_wsize, size);
    chk({tag, "_sends"}, n_send - s0, 1);
    chk({tag, "_acks"}, n_ack - a0, 1);
    chk({tag, "_pending"}, exp_q.size(), 0);
    bad = 0;
    for (int i = 0; i < size; i++)
      if (txm[i] != rxm[src_of(i)]) bad++;
    chk({tag, "_payload"}, bad, 0);
  endtask

  initial begin
    int a0, s0, wv0, rv0, t, bad;
    reset_i = 1'b1;
    enable_i = 1'b1;
    packet_avail_i = 1'b0;
    packet_req_i = 1'b1;
    packet_rsize_i = '0;
    repeat (3) tick();
    chk("reset_outputs",
        longint'({packet_rvalid_o, packet_ack_o, packet_wvalid_o,
                  packet_wsize_valid_o, packet_send_o,
                  packet_raddr_o, packet_waddr_o,
                  packet_rdata_size_o, packet_wdata_size_o,
                  packet_wsize_o, echo_count_o, drop_count_o}), 0);
    reset_i = 1'b0;
    tick();

    echo(64, 1, 0, 1'b0, "p64");
    chk("p64_echo_count", echo_count_o, 1);
    echo(61, 2, 0, 1'b0, "p61");
    chk("p61_echo_count", echo_count_o, 2);

    a0 = n_ack; s0 = n_send; wv0 = n_wv; rv0 = n_rv;
    exp_q.delete();
    packet_rsize_i = 12'd10;
    packet_avail_i = 1'b1;
    for (t = 0; t < 50 && n_ack == a0; t++) tick();
    packet_avail_i = 1'b0;
    repeat (3) tick();
    chk("runt_acks", n_ack - a0, 1);
    chk("runt_writes", n_wv - wv0, 0);
    chk("runt_reads", n_rv - rv0, 0);
    chk("runt_sends", n_send - s0, 0);
    chk("runt_drop_count", drop_count_o, 1);
    chk("runt_echo_count", echo_count_o, 2);

    echo(64, 3, 20, 1'b0, "req_late");
    chk("req_late_echo_count", echo_count_o, 3);

    load(64, 4, 1'b0);
    a0 = n_ack; s0 = n_send; rv0 = n_rv;
    packet_rsize_i = 12'd64;
    packet_avail_i = 1'b1;
    for (t = 0; t < 100 && (n_rv - rv0) < 5; t++) tick();
    chk("rst_reached_word5", n_rv - rv0, 5);
    reset_i = 1'b1;
    tick();
    chk("rst_mid_outputs",
        longint'({packet_rvalid_o, packet_ack_o, packet_wvalid_o,
                  packet_wsize_valid_o, packet_send_o,
                  packet_raddr_o, packet_waddr_o,
                  packet_rdata_size_o, packet_wdata_size_o,
                  packet_wsize_o, echo_count_o, drop_count_o}), 0);
    chk("rst_mid_no_ack", n_ack - a0, 0);
    chk("rst_mid_no_send", n_send - s0, 0);
    reset_i = 1'b0;
    echo(64, 4, 0, 1'b0, "reecho");
    chk("reecho_echo_count", echo_count_o, 1);
    chk("reecho_drop_count", drop_count_o, 0);

`ifdef ECHO_MAC_SWAP_EN
    echo(60, 5, 0, 1'b1, "swap60");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (txm[i] != 8'(21 + i)) bad++;
      if (txm[i + 6] != 8'(11 + i)) bad++;
    end
    chk("swap60_mac_bytes", bad, 0);
    chk("swap60_echo_count", echo_count_o, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
